// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit for the X/M stage.
// MULT uses radix-2 Booth, DIV uses restoring division on magnitudes.
// A start pulse loads operands; WIDTH iterations follow, then one DONE
// cycle registers the result and pulses data_resultRDY.
module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             start;

  // Shared datapath. MULT: {acc, q, qm1} is the Booth product register, acc
  // carries one guard bit so subtracting the most-negative multiplicand
  // cannot overflow. DIV: acc is the partial remainder, q shifts the
  // dividend out and the quotient in, mcand holds the divisor magnitude.
  logic             op_mult;
  logic             neg_res;
  logic             div_zero;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             qm1;
  logic [WIDTH-1:0] mcand;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic [WIDTH:0]   mult_hi;
  logic             mult_ovf;
  logic [WIDTH-1:0] quot_signed;

  assign start = ctrl_MULT | ctrl_DIV;
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Next-iteration arithmetic for both operations and the final result forms.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
    mcand_ext = {mcand[WIDTH-1], mcand};
    booth_sum = acc;
    case ({q[0], qm1})
      2'b01:   booth_sum = acc + mcand_ext;
      2'b10:   booth_sum = acc - mcand_ext;
      default: booth_sum = acc;
    endcase
    div_shift   = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_trial   = {1'b0, div_shift} - {2'b00, mcand};
    // Upper WIDTH+1 bits of the 2*WIDTH product must be a pure sign extension.
    mult_hi     = {acc[WIDTH-1:0], q[WIDTH-1]};
    mult_ovf    = ~((&mult_hi) | ~(|mult_hi));
    quot_signed = neg_res ? -q : q;
  end

  // Datapath: load on start, otherwise iterate while running.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; a start edge always loads them before any result is formed.
    if (start) begin
      op_mult  <= ctrl_MULT;
      acc      <= '0;
      qm1      <= 1'b0;
      neg_res  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= (data_operandB == '0);
      if (ctrl_MULT) begin
        mcand <= data_operandA;
        q     <= data_operandB;
      end else begin
        mcand <= abs_b;
        q     <= abs_a;
      end
    end else if (state == RUN) begin
      if (op_mult) begin
        acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q   <= {booth_sum[0], q[WIDTH-1:1]};
        qm1 <= q[0];
      end else if (div_trial[WIDTH+1]) begin
        acc <= div_shift;
        q   <= {q[WIDTH-2:0], 1'b0};
      end else begin
        acc <= div_trial[WIDTH:0];
        q   <= {q[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Control FSM with registered outputs; a start pulse restarts from any state.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register in this block sees pre-edge values.
    if (clr) begin
      state          <= IDLE;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_busy      <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        state     <= RUN;
        cnt       <= '0;
        data_busy <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= DONE;
          end
          DONE: begin
            state          <= IDLE;
            data_busy      <= 1'b0;
            data_resultRDY <= 1'b1;
            if (op_mult) begin
              data_result    <= q;
              data_exception <= mult_ovf;
            end else if (div_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else begin
              data_result    <= quot_signed;
              // A positive quotient with the top bit set only arises from min / -1.
              data_exception <= ~neg_res & q[WIDTH-1];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
